// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;

  localparam int NB_FLAGS  = 5;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_ERR  = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {Err,Ovf,Carry,Neg,Zero}.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0]  a_i,
  input  logic [NB_DATA-1:0]  b_i,
  input  logic [NB_OP-1:0]    op_i,
  output logic [NB_DATA-1:0]  result_o,
  output logic [NB_FLAGS-1:0] flags_o
);

  localparam int NB_SH = $clog2(NB_DATA);
  localparam int MSB   = NB_DATA - 1;

  logic [NB_DATA:0]   add_w;
  logic [NB_DATA:0]   sub_w;
  logic [NB_SH-1:0]   sh_w;
  logic [NB_DATA-1:0] res;
  logic               carry;
  logic               ovf;
  logic               err;

  // Extra top bit yields carry-out for add and borrow for sub.
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  assign sh_w  = b_i[NB_SH-1:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    unique case (op_i)
      NB_OP'(OP_ADD): begin
        res   = add_w[MSB:0];
        carry = add_w[NB_DATA];
        ovf   = (a_i[MSB] == b_i[MSB]) &&
                (add_w[MSB] != a_i[MSB]);
      end
      NB_OP'(OP_SUB): begin
        res   = sub_w[MSB:0];
        carry = sub_w[NB_DATA];
        ovf   = (a_i[MSB] != b_i[MSB]) &&
                (sub_w[MSB] != a_i[MSB]);
      end
      NB_OP'(OP_AND):  res = a_i & b_i;
      NB_OP'(OP_OR):   res = a_i | b_i;
      NB_OP'(OP_XOR):  res = a_i ^ b_i;
      NB_OP'(OP_NOR):  res = ~(a_i | b_i);
      NB_OP'(OP_SLT):
        res = {{(NB_DATA-1){1'b0}},
               $signed(a_i) < $signed(b_i)};
      NB_OP'(OP_SLTU):
        res = {{(NB_DATA-1){1'b0}}, a_i < b_i};
      NB_OP'(OP_SLL):  res = a_i << sh_w;
      NB_OP'(OP_SRL):  res = a_i >> sh_w;
      NB_OP'(OP_SRA):
        res = $unsigned($signed(a_i) >>> sh_w);
      default:         err = 1'b1;
    endcase
  end

  always_comb begin
    flags_o             = '0;
    flags_o[FLAG_ZERO]  = (res == '0);
    flags_o[FLAG_NEG]   = res[MSB];
    flags_o[FLAG_CARRY] = carry;
    flags_o[FLAG_OVF]   = ovf;
    flags_o[FLAG_ERR]   = err;
  end

  assign result_o = res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds
// the registered result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NB_DATA-1:0]  A,
  input  logic [NB_DATA-1:0]  B,
  input  logic [NB_OP-1:0]    Op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NB_DATA-1:0]  Result,
  output logic [NB_FLAGS-1:0] Flags
);

  logic                s1_valid_q, s1_valid_d;
  logic [NB_DATA-1:0]  s1_a_q, s1_a_d;
  logic [NB_DATA-1:0]  s1_b_q, s1_b_d;
  logic [NB_OP-1:0]    s1_op_q, s1_op_d;
  logic                s2_valid_q, s2_valid_d;
  logic [NB_DATA-1:0]  res_q, res_d;
  logic [NB_FLAGS-1:0] flags_q, flags_d;
  logic [NB_DATA-1:0]  core_res;
  logic [NB_FLAGS-1:0] core_flags;
  logic                s1_adv;
  logic                s2_adv;

  alu_core #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  // Ready chains from the output side only, never from in_valid.
  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    flags_d    = flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = core_res;
        flags_d = core_flags;
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = A;
        s1_b_d  = B;
        s1_op_d = Op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  // Outputs are forced quiet for the whole reset window, not just after the edge.
  assign in_ready  = !reset && s1_adv;
  assign out_valid = !reset && s2_valid_q;
  assign Result    = reset ? '0 : res_q;
  assign Flags     = reset ? '0 : flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at NB_DATA=32 and NB_DATA=8.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;

  typedef struct packed {
    logic [7:0] r;
    logic [4:0] f;
  } exp8_t;

  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] ANDO = 6'b100100;
  localparam logic [5:0] ORO  = 6'b100101;
  localparam logic [5:0] XORO = 6'b100110;
  localparam logic [5:0] NORO = 6'b100111;
  localparam logic [5:0] SLT  = 6'b101010;
  localparam logic [5:0] SLTU = 6'b101011;
  localparam logic [5:0] SLL  = 6'b000000;
  localparam logic [5:0] SRL  = 6'b000010;
  localparam logic [5:0] SRA  = 6'b000011;

  logic [5:0] oplist [0:11] = '{ADD, SUB, ANDO, ORO, XORO, NORO,
                                SLT, SLTU, SLL, SRL, SRA, 6'b010101};

  logic        clk = 1'b0;
  logic        rst, iv, ir, ov, ordy;
  logic [31:0] a, b, res;
  logic [5:0]  op;
  logic [4:0]  flg;
  logic        rst8, iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, res8;
  logic [5:0]  op8;
  logic [4:0]  flg8;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t  q[$];
  exp8_t q8[$];

  always #5 clk = ~clk;

  alu_pipe #(.NB_DATA(32), .NB_OP(6)) dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
    .A(a), .B(b), .Op(op), .out_valid(ov), .out_ready(ordy),
    .Result(res), .Flags(flg)
  );

  alu_pipe #(.NB_DATA(8), .NB_OP(6)) dut8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .Op(op8), .out_valid(ov8), .out_ready(or8),
    .Result(res8), .Flags(flg8)
  );

  // Reference: range checks on 64-bit arithmetic, not carry-bit tricks.
  function automatic exp_t model(logic [31:0] x, logic [31:0] y,
                                 logic [5:0] o);
    exp_t   e;
    longint sx, sy, s;
    logic [63:0] u;
    logic [4:0]  sh;
    e  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    case (o)
      ADD: begin
        s = sx + sy; u = {32'd0, x} + {32'd0, y};
        e.r = x + y; e.f[2] = (u > 64'h0000_0000_FFFF_FFFF);
        e.f[3] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      SUB: begin
        s = sx - sy; e.r = x - y; e.f[2] = (x < y);
        e.f[3] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ANDO: e.r = x & y;
      ORO:  e.r = x | y;
      XORO: e.r = x ^ y;
      NORO: e.r = ~(x | y);
      SLT:  e.r = (sx < sy) ? 32'd1 : 32'd0;
      SLTU: e.r = (x < y) ? 32'd1 : 32'd0;
      SLL:  e.r = x << sh;
      SRL:  e.r = x >> sh;
      SRA:  e.r = $unsigned($signed(x) >>> sh);
      default: e.f[4] = 1'b1;
    endcase
    e.f[0] = (e.r == 32'd0);
    e.f[1] = e.r[31];
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1; rst8 = 1'b1; iv = 1'b0; iv8 = 1'b0;
    ordy = 1'b1; or8 = 1'b1;
    a = '0; b = '0; op = '0; a8 = '0; b8 = '0; op8 = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ir !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 0", ir);
    end
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", ov);
    end
    n_cmp++;
    if (res !== 32'd0 || flg !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_result: got %h/%b want 0/0", res, flg);
    end
    n_cmp++;
    if (ir8 !== 1'b0 || ov8 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset8_hs: got %b%b want 00", ir8, ov8);
    end
    rst = 1'b0; rst8 = 1'b0;
    #1;
    n_cmp++;
    if (ir !== 1'b1 || ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_ready: got %b%b want 11", ir, ir8);
    end
  endtask

  task automatic test_add_ovf;
    exp_t e;
    @(negedge clk);
    iv = 1'b1; a = 32'h7FFF_FFFF; b = 32'h1; op = ADD; ordy = 1'b1;
    #1;
    if (iv && ir) q.push_back('{32'h8000_0000, 5'b01010});
    @(negedge clk);
    iv = 1'b0;
    #1;
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++; $display("FAIL add_early: got out_valid %b want 0", ov);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ov !== 1'b1 || q.size() == 0) begin
      n_bad++; $display("FAIL add_latency: got out_valid %b want 1", ov);
    end else begin
      e = q.pop_front();
      n_cmp++;
      if (res !== e.r || flg !== e.f) begin
        n_bad++;
        $display("FAIL add_ovf: got %h/%b want %h/%b",
                 res, flg, e.r, e.f);
      end
    end
  endtask

  task automatic test_sub_b2b;
    exp_t e;
    @(negedge clk);
    iv = 1'b1; a = 32'd5; b = 32'd5; op = SUB; ordy = 1'b1;
    #1;
    if (ir) q.push_back('{32'h0, 5'b00001});
    @(negedge clk);
    a = 32'd3; b = 32'd7;
    #1;
    if (ir) q.push_back('{32'hFFFF_FFFC, 5'b00110});
    @(negedge clk);
    iv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (ov !== 1'b1 || q.size() == 0) begin
        n_bad++; $display("FAIL sub_b2b_valid%0d: got %b want 1", i, ov);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (res !== e.r || flg !== e.f) begin
          n_bad++;
          $display("FAIL sub_b2b%0d: got %h/%b want %h/%b",
                   i, res, flg, e.r, e.f);
        end
      end
    end
  endtask

  task automatic test_shift;
    exp_t e;
    @(negedge clk);
    iv = 1'b1; a = 32'h8000_0000; b = 32'h24; op = SRA; ordy = 1'b1;
    #1;
    if (ir) q.push_back('{32'hF800_0000, 5'b00010});
    @(negedge clk);
    op = SRL;
    #1;
    if (ir) q.push_back('{32'h0800_0000, 5'b00000});
    @(negedge clk);
    iv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (ov !== 1'b1 || q.size() == 0) begin
        n_bad++; $display("FAIL shift_valid%0d: got %b want 1", i, ov);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (res !== e.r || flg !== e.f) begin
          n_bad++;
          $display("FAIL shift%0d: got %h/%b want %h/%b",
                   i, res, flg, e.r, e.f);
        end
      end
    end
  endtask

  task automatic test_illegal;
    exp_t e;
    @(negedge clk);
    iv = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    op = 6'b111111; ordy = 1'b1;
    #1;
    if (ir) q.push_back('{32'h0, 5'b10001});
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ov !== 1'b1 || q.size() == 0) begin
      n_bad++; $display("FAIL illegal_valid: got %b want 1", ov);
    end else begin
      e = q.pop_front();
      n_cmp++;
      if (res !== e.r || flg !== e.f) begin
        n_bad++;
        $display("FAIL illegal_op: got %h/%b want %h/%b",
                 res, flg, e.r, e.f);
      end
    end
  endtask

  task automatic test_stall_stream;
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [5:0]  so [8];
    logic [31:0] hold_r;
    logic [4:0]  hold_f;
    exp_t e;
    int sent = 0;
    int got = 0;
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      so[i] = oplist[$urandom_range(0, 11)];
    end
    hold_r = '0; hold_f = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      ordy = !(c >= 3 && c < 8);
      iv = (sent < 8);
      if (sent < 8) begin
        a = sa[sent]; b = sb[sent]; op = so[sent];
      end
      #1;
      if (c == 3) begin
        hold_r = res; hold_f = flg;
      end
      if (c >= 4 && c < 8) begin
        n_cmp++;
        if (ir !== 1'b0 || res !== hold_r || flg !== hold_f) begin
          n_bad++;
          $display("FAIL stall_hold c%0d: got rdy %b %h/%b want 0 %h/%b",
                   c, ir, res, flg, hold_r, hold_f);
        end
      end
      if (iv && ir) begin
        q.push_back(model(a, b, op));
        sent++;
      end
      if (ov && ordy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: got output, want none");
        end else begin
          e = q.pop_front();
          if (res !== e.r || flg !== e.f) begin
            n_bad++;
            $display("FAIL stream%0d: got %h/%b want %h/%b",
                     got, res, flg, e.r, e.f);
          end
        end
        got++;
      end
    end
    iv = 1'b0; ordy = 1'b1;
    n_cmp++;
    if (got != 8 || q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got %0d left %0d want 8 left 0",
               got, q.size());
    end
  endtask

  task automatic test_nb8;
    exp8_t e;
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; op8 = ADD; or8 = 1'b1;
    #1;
    if (ir8) q8.push_back('{8'h00, 5'b00101});
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b1 || q8.size() == 0) begin
      n_bad++; $display("FAIL nb8_valid: got %b want 1", ov8);
    end else begin
      e = q8.pop_front();
      n_cmp++;
      if (res8 !== e.r || flg8 !== e.f) begin
        n_bad++;
        $display("FAIL nb8_add: got %h/%b want %h/%b",
                 res8, flg8, e.r, e.f);
      end
    end
    @(negedge clk);
    iv8 = 1'b1; or8 = 1'b0; a8 = 8'h10; b8 = 8'h20; op8 = ADD;
    @(negedge clk);
    a8 = 8'h33; op8 = XORO;
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    n_cmp++;
    if (ov8 !== 1'b1) begin
      n_bad++; $display("FAIL nb8_inflight: got %b want 1", ov8);
    end
    rst8 = 1'b1;
    #1;
    n_cmp++;
    if (ov8 !== 1'b0 || ir8 !== 1'b0 || res8 !== 8'h0) begin
      n_bad++;
      $display("FAIL nb8_in_reset: got %b%b %h want 00 00",
               ov8, ir8, res8);
    end
    @(negedge clk);
    rst8 = 1'b0; or8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ov8 !== 1'b0) begin
        n_bad++; $display("FAIL nb8_flushed%0d: got %b want 0", i, ov8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_b2b();
    test_shift();
    test_illegal();
    test_stall_stream();
    test_nb8();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
